// File: rtl/csr_unit.sv
// CSR unit: scratch CSRs plus optional cycle/instret counters behind a
// valid/ready request port, with a 3-state IDLE/EXEC/RESP sequencer.
//
// Optional feature macro: CSR_COUNTERS_EN (counters at 0xC00/0xC02/0xC80/0xC82).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid, o_ready  request handshake (o_ready only in IDLE)
//   i_op, i_addr      00 RW, 01 RS, 10 RC, 11 RD; 12-bit CSR address
//   i_src             write / mask operand
//   i_retire          one instruction retired this cycle
//   o_valid           one-cycle result pulse
//   o_dest            old CSR value (0 when illegal)
//   o_illegal         access illegal, qualified by o_valid
module csr_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [11:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_src,
  input  logic                  i_retire,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_dest,
  output logic                  o_illegal
);

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  localparam logic [11:0] SCR_BASE = 12'h340;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [1:0]            op_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] src_q;

  logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];

  logic [DATA_WIDTH-1:0] dest_q;
  logic                  illegal_q;

  logic                   accept;
  logic [NUM_SCRATCH-1:0] sc_sel;
  logic                   sc_hit;
  logic [DATA_WIDTH-1:0]  sc_old;
  logic                   cnt_hit;
  logic [DATA_WIDTH-1:0]  cnt_old;
  logic                   src_zero;
  logic                   legal;
  logic                   wr_en;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  old_val;
  logic [DATA_WIDTH-1:0]  new_val;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  o_ready = 1'b1;
      S_RESP:  o_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = o_ready && i_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q   <= OP_RD;
      addr_q <= '0;
      src_q  <= '0;
    end else if (accept) begin
      op_q   <= i_op;
      addr_q <= i_addr;
      src_q  <= i_src;
    end
  end

  // Scratch decode; addresses are distinct so at most one select is set.
  always_comb begin
    sc_sel = '0;
    sc_hit = 1'b0;
    sc_old = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (addr_q == 12'(SCR_BASE + 12'(i))) begin
        sc_sel[i] = 1'b1;
        sc_hit    = 1'b1;
        sc_old    = scratch_q[i];
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  localparam int  XW     = 2 * DATA_WIDTH;
  localparam bit  HAS_HI = (DATA_WIDTH == 32);

  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [XW-1:0]        cyc_x;
  logic [XW-1:0]        ins_x;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (i_retire) instret_q <= instret_q + 1'b1;
    end
  end

  // Zero-extend so bits above CNT_WIDTH read as 0.
  assign cyc_x = XW'(cycle_q);
  assign ins_x = XW'(instret_q);

  always_comb begin
    cnt_hit = 1'b0;
    cnt_old = '0;
    case (addr_q)
      12'hC00: begin
        cnt_hit = 1'b1;
        cnt_old = cyc_x[DATA_WIDTH-1:0];
      end
      12'hC02: begin
        cnt_hit = 1'b1;
        cnt_old = ins_x[DATA_WIDTH-1:0];
      end
      12'hC80: if (HAS_HI) begin
        cnt_hit = 1'b1;
        cnt_old = cyc_x[XW-1:DATA_WIDTH];
      end
      12'hC82: if (HAS_HI) begin
        cnt_hit = 1'b1;
        cnt_old = ins_x[XW-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end
`else
  logic unused_retire;
  assign unused_retire = i_retire;
  assign cnt_hit       = 1'b0;
  assign cnt_old       = '0;
`endif

  assign src_zero = (src_q == '0);

  // Legality and old value; illegal accesses report 0 and never write.
  always_comb begin
    legal   = 1'b0;
    wr_en   = 1'b0;
    old_val = '0;
    unique case (1'b1)
      sc_hit: begin
        legal   = 1'b1;
        wr_en   = (op_q != OP_RD);
        old_val = sc_old;
      end
      cnt_hit: begin
        legal   = (op_q == OP_RD) ||
                  ((op_q != OP_RW) && src_zero);
        old_val = legal ? cnt_old : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = old_val | src_q;
      OP_RC:   new_val = old_val & ~src_q;
      default: new_val = old_val;
    endcase
  end

  assign commit = (state_q == S_EXEC) && wr_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        scratch_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (sc_sel[i]) scratch_q[i] <= new_val;
    end
  end

  // Result registers load at the end of EXEC and hold until the next one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dest_q    <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      dest_q    <= old_val;
      illegal_q <= !legal;
    end
  end

  assign o_dest    = dest_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [31:0] src;
  logic        retire;
  logic        ovalid;
  logic [31:0] dest;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_op      (op),
    .i_addr    (addr),
    .i_src     (src),
    .i_retire  (retire),
    .o_valid   (ovalid),
    .o_dest    (dest),
    .o_illegal (illegal)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after RESP.
  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [11:0] a,
                       input logic [31:0] s,
                       input logic [31:0] ed,
                       input logic ei);
    chk({tag, ".ready"}, 64'(ready), 64'd1);
    valid = 1'b1;
    op    = o;
    addr  = a;
    src   = s;
    @(negedge clk);
    valid = 1'b0;
    src   = 32'hA5A5_A5A5;
    chk({tag, ".exec_vld"}, 64'(ovalid), 64'd0);
    @(negedge clk);
    chk({tag, ".vld"}, 64'(ovalid), 64'd1);
    chk({tag, ".dest"}, 64'(dest), 64'(ed));
    chk({tag, ".ill"}, 64'(illegal), 64'(ei));
    @(negedge clk);
    chk({tag, ".vld_drop"}, 64'(ovalid), 64'd0);
    chk({tag, ".hold"}, 64'(dest), 64'(ed));
  endtask

`ifdef CSR_COUNTERS_EN
  logic [31:0] v1;

  task automatic rd_val(input logic [11:0] a,
                        output logic [31:0] v);
    valid = 1'b1;
    op    = 2'b11;
    addr  = a;
    src   = '0;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    v = dest;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    op     = 2'b00;
    addr   = '0;
    src    = '0;
    retire = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.vld", 64'(ovalid), 64'd0);
    chk("rst.dest", 64'(dest), 64'd0);
    chk("rst.ill", 64'(illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 64'(ready), 64'd1);

    do_op("rw340", 2'b00, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_op("rd340", 2'b11, 12'h340, 32'h0, 32'hDEAD_BEEF, 1'b0);

    do_op("rw341", 2'b00, 12'h341, 32'h0000_F0F0, 32'h0, 1'b0);
    do_op("rs341", 2'b01, 12'h341, 32'h0000_0F00, 32'h0000_F0F0, 1'b0);
    do_op("rc341", 2'b10, 12'h341, 32'h0000_00F0, 32'h0000_FFF0, 1'b0);
    do_op("rd341", 2'b11, 12'h341, 32'h0, 32'h0000_FF00, 1'b0);

    do_op("rw343", 2'b00, 12'h343, 32'h1234_0001, 32'h0, 1'b0);
    do_op("rd343", 2'b11, 12'h343, 32'h0, 32'h1234_0001, 1'b0);
    do_op("rw344", 2'b00, 12'h344, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_op("rd33f", 2'b11, 12'h33F, 32'h0, 32'h0, 1'b1);
    do_op("rd7ff", 2'b11, 12'h7FF, 32'h0, 32'h0, 1'b1);
    do_op("rd340b", 2'b11, 12'h340, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef CSR_COUNTERS_EN
    rd_val(12'hC00, v1);
    do_op("rwc00", 2'b00, 12'hC00, 32'h55, 32'h0, 1'b1);
    do_op("rdc00", 2'b11, 12'hC00, 32'h0, v1 + 32'd6, 1'b0);
    do_op("rsc00z", 2'b01, 12'hC00, 32'h0, v1 + 32'd9, 1'b0);
    do_op("rcc00", 2'b10, 12'hC00, 32'h1, 32'h0, 1'b1);
    dut.cycle_q = 64'h0000_0000_FFFF_FFF0;
    do_op("rdc80a", 2'b11, 12'hC80, 32'h0, 32'h0, 1'b0);
    repeat (20) @(negedge clk);
    do_op("rdc80b", 2'b11, 12'hC80, 32'h0, 32'h1, 1'b0);
    retire = 1'b1;
    repeat (10) @(negedge clk);
    retire = 1'b0;
    do_op("rdc02", 2'b11, 12'hC02, 32'h0, 32'd10, 1'b0);
    do_op("rdc82", 2'b11, 12'hC82, 32'h0, 32'd0, 1'b0);
`else
    do_op("rwc00", 2'b00, 12'hC00, 32'h55, 32'h0, 1'b1);
    do_op("rdc00", 2'b11, 12'hC00, 32'h0, 32'h0, 1'b1);
    do_op("rdc02", 2'b11, 12'hC02, 32'h0, 32'h0, 1'b1);
    do_op("rdc80", 2'b11, 12'hC80, 32'h0, 32'h0, 1'b1);
    do_op("rdc82", 2'b11, 12'hC82, 32'h0, 32'h0, 1'b1);
`endif

    valid = 1'b1;
    op    = 2'b00;
    addr  = 12'h340;
    src   = 32'd5;
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("midrst.vld0", 64'(ovalid), 64'd0);
    @(negedge clk);
    chk("midrst.vld1", 64'(ovalid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.vld2", 64'(ovalid), 64'd0);
    chk("midrst.ready", 64'(ready), 64'd1);
    do_op("midrst.rd", 2'b11, 12'h340, 32'h0, 32'h0, 1'b0);

    do_op("rw340c", 2'b00, 12'h340, 32'h1234_5678, 32'h0, 1'b0);
    valid = 1'b1;
    op    = 2'b11;
    addr  = 12'h340;
    src   = '0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("hold.rdy%0d", k), 64'(ready),
          64'((k % 3) == 0));
      chk($sformatf("hold.vld%0d", k), 64'(ovalid),
          64'((k % 3) == 2));
      if ((k % 3) == 2)
        chk($sformatf("hold.dst%0d", k), 64'(dest),
            64'h1234_5678);
      @(negedge clk);
    end
    valid = 1'b0;
    chk("hold.end_vld", 64'(ovalid), 64'd0);
    @(negedge clk);
    chk("hold.idle_vld", 64'(ovalid), 64'd0);
    chk("hold.idle_rdy", 64'(ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (32 or 64 only).
REQ-002 SHALL have parameter NUM_SCRATCH, default 4, scratch CSR count (1..16) at addresses 0x340..0x340+NUM_SCRATCH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 64, width of cycle/instret counters.
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_valid  in  1  request present.
REQ-007 SHALL have port o_ready  out  1  unit can accept request.
REQ-008 SHALL have port i_op  in  2  00 RW, 01 RS (set bits), 10 RC (clear bits), 11 RD (read only).
REQ-009 SHALL have port i_addr  in  12  CSR address.
REQ-010 SHALL have port i_src  in  DATA_WIDTH  write/mask operand.
REQ-011 SHALL have port i_retire  in  1  one instruction retired this cycle.
REQ-012 SHALL have port o_valid  out  1  result pulse.
REQ-013 SHALL have port o_dest  out  DATA_WIDTH  old CSR value.
REQ-014 SHALL have port o_illegal  out  1  access illegal; qualified by o_valid.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; o_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with i_valid=1 and o_ready=1 in IDLE, capturing i_op, i_addr, i_src; i_valid in other states ignored.
REQ-017 SHALL in EXEC read old value, compute new = RW:src, RS:old|src, RC:old&~src, RD:old, and write it (legal writable target only) at end of EXEC.
REQ-018 SHALL in RESP drive o_valid=1 for exactly one cycle with o_dest=old value, o_illegal per REQ-020/021; o_dest and o_illegal hold until next RESP.
REQ-019 SHALL give latency 2 cycles accept-to-o_valid, throughput one op per 3 cycles.
REQ-020 SHALL flag unmapped addresses illegal: o_dest=0, no state change.
REQ-021 SHALL treat counter CSRs as read-only: RW, or RS/RC with i_src!=0, is illegal, o_dest=0, no write; RS/RC with i_src=0 and RD are legal.
REQ-022 SHALL increment cycle counter every cycle out of reset, wrapping modulo 2^CNT_WIDTH.
REQ-023 SHALL increment instret by 1 on each cycle with i_retire=1, wrapping modulo 2^CNT_WIDTH.
REQ-024 SHALL map cycle low/high at 0xC00/0xC80 and instret low/high at 0xC02/0xC82; high halves exist only when DATA_WIDTH=32, otherwise unmapped; bits above CNT_WIDTH read 0.
REQ-025 SHALL return the counter value registered at the start of EXEC (increment in the same cycle not visible).

Reset
REQ-026 SHALL on i_rst=1: FSM to IDLE, o_valid=0, o_dest=0, o_illegal=0, all scratch CSRs and counters to 0, o_ready=1 the cycle after reset deasserts.
REQ-027 SHALL abandon an in-flight op on reset mid-operation: no write committed after reset, no o_valid pulse.

Configuration
REQ-028 SHALL with macro CSR_COUNTERS_EN defined implement counters per REQ-021..025.
REQ-029 SHALL with CSR_COUNTERS_EN undefined omit counter registers; 0xC00/0xC80/0xC02/0xC82 are unmapped (illegal, o_dest=0); i_retire ignored.

Verification
REQ-030 SHALL test RW 0x340 src=0xDEADBEEF then RD 0x340 -> o_dest 0 then 0xDEADBEEF, o_illegal=0, o_valid 2 cycles after each accept.
REQ-031 SHALL test 0x341=0x0000F0F0, RS src=0x0F00 -> o_dest 0xF0F0, then RC src=0x00F0 -> o_dest 0xFFF0, final RD -> 0xFF00.
REQ-032 SHALL test RW to 0xC00 and RD to 0x7FF -> o_illegal=1, o_dest=0, cycle counter unaffected.
REQ-033 SHALL test cycle wrap: force cycle to 0xFFFF_FFFF low via 64-bit preload in bench, RD 0xC80 before/after -> high half increments by 1; i_retire held 10 cycles -> instret reads 10.
REQ-034 SHALL test reset asserted during EXEC of RW 0x340 src=5 -> no o_valid, RD 0x340 after reset returns 0.
REQ-035 SHALL test i_valid held high across all states -> exactly one accept per 3 cycles, no extra o_valid pulses.
